// File: rtl/ser_feed.sv
// ser_feed: parallel-to-serial feeder for a downstream shift register.
// A word is captured on LOAD while READY, then presented one bit per cycle on
// SOUT, qualified by SEN; STALL freezes the word in place. A one-cycle FIN
// state follows the last bit, pulsing DONE before READY returns.
module ser_feed #(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         LOAD,
  input  logic [N-1:0] D,
  input  logic         STALL,
  output logic         READY,
  output logic         SOUT,
  output logic         SEN,
  output logic         DONE
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_FIN   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] sel_idx;

  // Next-state logic: capture on LOAD in IDLE, advance count unless stalled.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (LOAD) begin
          buf_d   = D;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!STALL) begin
          // Last bit leaves FIN-bound without bumping cnt, so it never wraps.
          if (cnt_q == LAST) begin
            state_d = S_FIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode purely from state so reset forces them without an edge.
  always_comb begin
    sel_idx = MSB_FIRST ? (LAST - cnt_q) : cnt_q;
    READY   = (state_q == S_IDLE);
    DONE    = (state_q == S_FIN);
    SEN     = (state_q == S_SHIFT) && !STALL;
    SOUT    = (state_q == S_SHIFT) ? buf_q[sel_idx] : 1'b0;
  end

endmodule
